// File: rtl/add_acc_pipe.sv
// add_acc_pipe: one-entry valid/ready pipeline computing a+b or a saturating running sum,
// with a sticky saturation flag and a wrapping accepted-beat counter.
module add_acc_pipe #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             mode,
    input  logic             clr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   sum,
    output logic             ovf,
    output logic [CNT_W-1:0] txn_cnt
);
    logic [WIDTH:0]   acc, acc_new, add_res;
    logic [WIDTH+1:0] acc_ext;
    logic             accept, sat;

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    // A clear on the same edge as an accumulate beat makes that beat start from zero
    always_comb begin
        acc_ext = {1'b0, (clr ? {(WIDTH+1){1'b0}} : acc)} + {2'b00, a};
        sat     = acc_ext[WIDTH+1];
        acc_new = sat ? {(WIDTH+1){1'b1}} : acc_ext[WIDTH:0];
        add_res = {1'b0, a} + {1'b0, b};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            sum       <= '0;
            ovf       <= 1'b0;
            txn_cnt   <= '0;
            acc       <= '0;
        end else if (accept) begin
            out_valid <= 1'b1;
            sum       <= mode ? acc_new : add_res;
            txn_cnt   <= txn_cnt + CNT_W'(1);
            if (mode) begin
                acc <= acc_new;
                ovf <= (ovf && !clr) || sat;
            end else if (clr) begin
                acc <= '0;
                ovf <= 1'b0;
            end
        end else begin
            if (out_ready) out_valid <= 1'b0;
            if (clr) begin
                acc <= '0;
                ovf <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_add_acc_pipe.sv
// tb_add_acc_pipe: directed and random stimulus scored against a queue-based reference model.
module tb_add_acc_pipe;
    localparam int W = 4;
    localparam int CW = 2;
    localparam int SMAX = (1 << (W + 1)) - 1;

    logic          clk = 0, rst_n = 0;
    logic          in_valid = 0, in_ready, mode = 0, clr = 0, out_valid, out_ready = 1, ovf;
    logic [W-1:0]  a = 0, b = 0;
    logic [W:0]    sum;
    logic [CW-1:0] txn_cnt;

    int total = 0, bad = 0;
    int exp_q[$];
    int m_acc = 0, m_cnt = 0;
    bit m_ovf = 0;

    add_acc_pipe #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .mode(mode), .clr(clr), .out_valid(out_valid),
        .out_ready(out_ready), .sum(sum), .ovf(ovf), .txn_cnt(txn_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, want, $time);
        end
    endtask

    // One cycle of stimulus; the model decides acceptance from its own view of the pipeline.
    task automatic cyc(input bit iv, input int ia, input int ib, input bit im, input bit ic, input bit ordy);
        bit exp_rdy, acc_ok, sat;
        int t;
        @(negedge clk);
        #1;
        in_valid = iv; a = W'(ia); b = W'(ib); mode = im; clr = ic; out_ready = ordy;
        exp_rdy = (exp_q.size() == 0) || ordy;
        #2;
        chk("in_ready", int'(in_ready), int'(exp_rdy));
        acc_ok = iv && exp_rdy;
        if (acc_ok) begin
            m_cnt = (m_cnt + 1) % (1 << CW);
            if (im) begin
                t = (ic ? 0 : m_acc) + ia;
                sat = t > SMAX;
                m_acc = sat ? SMAX : t;
                m_ovf = (m_ovf && !ic) || sat;
                exp_q.push_back(m_acc);
            end else begin
                exp_q.push_back(ia + ib);
                if (ic) begin m_acc = 0; m_ovf = 0; end
            end
        end else if (ic) begin
            m_acc = 0; m_ovf = 0;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 1);
    endtask

    task automatic reset_mid;
        @(posedge clk);
        #2;
        rst_n = 0;
        in_valid = 0;
        #1;
        chk("rst out_valid", int'(out_valid), 0);
        chk("rst sum", int'(sum), 0);
        chk("rst ovf", int'(ovf), 0);
        chk("rst txn_cnt", int'(txn_cnt), 0);
        chk("rst in_ready", int'(in_ready), 1);
        exp_q.delete();
        m_acc = 0; m_ovf = 0; m_cnt = 0;
        @(negedge clk);
        #1;
        rst_n = 1;
    endtask

    // Monitor: compares held results against the scoreboard, pops on consumption.
    initial forever begin
        @(negedge clk);
        #2;
        if (rst_n) begin
            chk("out_valid", int'(out_valid), int'(exp_q.size() != 0));
            chk("ovf", int'(ovf), int'(m_ovf));
            chk("txn_cnt", int'(txn_cnt), m_cnt);
            if (out_valid && exp_q.size() != 0) begin
                chk("sum", int'(sum), exp_q[0]);
                if (out_ready) void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        #3;
        chk("reset out_valid", int'(out_valid), 0);
        chk("reset sum", int'(sum), 0);
        chk("reset ovf", int'(ovf), 0);
        chk("reset txn_cnt", int'(txn_cnt), 0);
        chk("reset in_ready", int'(in_ready), 1);
        @(negedge clk);
        #1;
        rst_n = 1;
        cyc(1, 4, 4, 0, 0, 1);
        cyc(1, 15, 15, 0, 0, 1);
        idle(1);
        cyc(0, 0, 0, 0, 1, 1);
        cyc(1, 10, 0, 1, 0, 1);
        cyc(1, 10, 0, 1, 0, 1);
        cyc(1, 10, 0, 1, 0, 1);
        cyc(1, 5, 0, 1, 0, 1);
        cyc(0, 0, 0, 0, 1, 1);
        idle(1);
        cyc(1, 3, 4, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        cyc(1, 1, 1, 0, 0, 1);
        idle(1);
        cyc(0, 0, 0, 0, 1, 1);
        cyc(1, 10, 0, 1, 0, 1);
        cyc(1, 10, 0, 1, 0, 1);
        cyc(1, 6, 0, 1, 1, 1);
        idle(1);
        cyc(1, 15, 0, 1, 0, 1);
        cyc(1, 15, 0, 1, 0, 1);
        cyc(1, 15, 0, 1, 0, 1);
        cyc(1, 15, 15, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        reset_mid();
        for (int i = 0; i < 5; i++) cyc(1, i, i + 1, 0, 0, 1);
        idle(1);
        for (int i = 0; i < 400; i++)
            cyc($urandom_range(3) != 0, $urandom_range(15), $urandom_range(15), $urandom_range(1) == 1,
                $urandom_range(7) == 0, $urandom_range(3) != 0);
        idle(3);
        chk("drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/add_acc_pipe.md
ADD_ACC_PIPE -- requirements
Module: add_acc_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 4, operand width in bits (legal 2..32).
REQ-002 SHALL have parameter CNT_W, default 8, width of the accepted-transaction counter.
REQ-003 SHALL have port clk  input  1  single rising-edge clock for all state.
REQ-004 SHALL have port rst_n  input  1  reset; asynchronous, active-low.
REQ-005 SHALL have port in_valid  input  1  operand beat present.
REQ-006 SHALL have port in_ready  output  1  block can accept a beat this cycle.
REQ-007 SHALL have port a  input  WIDTH  first operand, unsigned.
REQ-008 SHALL have port b  input  WIDTH  second operand, unsigned; ignored in accumulate mode.
REQ-009 SHALL have port mode  input  1  0 = add (a+b), 1 = accumulate (acc+a); sampled with the beat.
REQ-010 SHALL have port clr  input  1  synchronous clear of accumulator and ovf.
REQ-011 SHALL have port out_valid  output  1  result held on sum.
REQ-012 SHALL have port out_ready  input  1  consumer takes the result this cycle.
REQ-013 SHALL have port sum  output  WIDTH+1  registered result, unsigned.
REQ-014 SHALL have port ovf  output  1  sticky accumulator saturation flag.
REQ-015 SHALL have port txn_cnt  output  CNT_W  number of accepted beats, wraps modulo 2^CNT_W.

Function
REQ-016 SHALL accept a beat on a rising clk edge when in_valid && in_ready.
REQ-017 SHALL drive in_ready = !out_valid || out_ready (combinational, one-entry pipeline, full throughput under continuous out_ready=1).
REQ-018 SHALL present the result of an accepted beat on sum with out_valid=1 exactly one cycle after acceptance (latency 1).
REQ-019 SHALL hold sum and out_valid stable while out_valid=1 and out_ready=0.
REQ-020 SHALL clear out_valid on an edge with out_ready=1 and no new beat accepted; with a new beat accepted the same edge, out_valid stays 1 and sum updates.
REQ-021 SHALL, in add mode, produce sum = zero-extended a + zero-extended b, never overflowing WIDTH+1 bits, and leave the accumulator unchanged.
REQ-022 SHALL, in accumulate mode, compute acc_next = acc + a in WIDTH+2 bits, saturate to 2^(WIDTH+1)-1 if larger, store it in the WIDTH+1-bit accumulator and output it on sum.
REQ-023 SHALL set ovf on any accumulate beat that saturates; ovf SHALL stay 1 until clr or reset.
REQ-024 SHALL, on clr=1 with no beat accepted, set accumulator=0 and ovf=0 at the edge; sum/out_valid unaffected.
REQ-025 SHALL, on clr=1 with an accumulate beat accepted the same edge, use acc=0 as the base (result = a, ovf reflects only this beat).
REQ-026 SHALL, on clr=1 with an add beat accepted, perform the add normally and clear accumulator and ovf.
REQ-027 SHALL increment txn_cnt by 1 on every accepted beat, wrapping from 2^CNT_W-1 to 0; clr SHALL NOT affect txn_cnt.
REQ-028 SHALL ignore a, b, mode and clr-free inputs when no beat is accepted (no state change except REQ-020/REQ-024).

Reset
REQ-029 SHALL, while rst_n=0, asynchronously force out_valid=0, sum=0, ovf=0, txn_cnt=0, accumulator=0.
REQ-030 SHALL drive in_ready=1 during and after reset (follows REQ-017 with out_valid=0).
REQ-031 SHALL discard any beat in flight when reset asserts mid-operation; first edge after rst_n rises SHALL be able to accept a beat.

Verification
REQ-032 SHALL cover add: WIDTH=4, out_ready=1, beat a=4,b=4 mode=0 -> next cycle sum=8, out_valid=1, txn_cnt=1; then a=15,b=15 -> sum=30.
REQ-033 SHALL cover accumulate with saturation: clr pulse, then beats a=10,10,10,5 mode=1 -> sums 10,20,30,31, ovf=0,0,0,1; then clr -> ovf=0.
REQ-034 SHALL cover backpressure: beat a=3,b=4 accepted, out_ready=0 for 3 cycles -> sum=7 held, out_valid=1, in_ready=0; out_ready=1 -> in_ready=1, next beat accepted.
REQ-035 SHALL cover clr-with-beat: acc=20, clr=1 with accumulate a=6 -> sum=6, ovf=0.
REQ-036 SHALL cover reset mid-operation: out_valid=1, sum=30, ovf=1, rst_n low mid-cycle -> all outputs 0 immediately without a clk edge.
REQ-037 SHALL cover txn_cnt wrap: CNT_W=2, 5 accepted beats -> txn_cnt sequence 1,2,3,0,1.
